// File: rtl/fwd_hazard_tracker_if.sv
// ---------------------------------------------------------------------------
// fwd_hazard_tracker_if
// Bundle between the EX-stage control and the forwarding/hazard tracker.
//   ex_valid, ex_src, ex_rd, ex_regwrite, ex_is_load : EX instruction info
//   hold, flush                                      : pipeline freeze / kill
//   fwd_sel, stall                                   : tracker results
//   stall_count                                      : only with FWD_STATS_EN
// Modports: master = pipeline control, slave = tracker.
// Optional feature macro: FWD_STATS_EN.
// ---------------------------------------------------------------------------
interface fwd_hazard_tracker_if #(
  parameter int NUM_SRC = 2,
  parameter int REG_W   = 5,
  parameter int DEPTH   = 2
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  logic                       ex_valid;
  logic [NUM_SRC*REG_W-1:0]   ex_src;
  logic [REG_W-1:0]           ex_rd;
  logic                       ex_regwrite;
  logic                       ex_is_load;
  logic                       hold;
  logic                       flush;
  logic [NUM_SRC*SEL_W-1:0]   fwd_sel;
  logic                       stall;

`ifdef FWD_STATS_EN
  logic [15:0]                stall_count;

  modport master (
    output ex_valid, ex_src, ex_rd, ex_regwrite, ex_is_load, hold, flush,
    input  fwd_sel, stall, stall_count
  );
  modport slave (
    input  ex_valid, ex_src, ex_rd, ex_regwrite, ex_is_load, hold, flush,
    output fwd_sel, stall, stall_count
  );
`else
  modport master (
    output ex_valid, ex_src, ex_rd, ex_regwrite, ex_is_load, hold, flush,
    input  fwd_sel, stall
  );
  modport slave (
    input  ex_valid, ex_src, ex_rd, ex_regwrite, ex_is_load, hold, flush,
    output fwd_sel, stall
  );
`endif
endinterface

// File: rtl/fwd_hazard_tracker.sv
// ---------------------------------------------------------------------------
// fwd_hazard_tracker
// Forwarding-select and load-use stall unit beside the EX stage. A shadow
// pipeline of DEPTH entries {v, rd, ld} mirrors the post-EX pipeline
// registers (entry 1 = EX/MEM, entry DEPTH = last writer before the RF).
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : fwd_hazard_tracker_if.slave (EX info in, fwd_sel/stall out)
// Parameters: NUM_SRC, REG_W, DEPTH (1..7), LOAD_LAT (< DEPTH).
// Optional feature macro: FWD_STATS_EN adds the saturating stall_count.
// ---------------------------------------------------------------------------
module fwd_hazard_tracker #(
  parameter int NUM_SRC  = 2,
  parameter int REG_W    = 5,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  fwd_hazard_tracker_if.slave bus
);
  localparam int SEL_W = $clog2(DEPTH + 1);

  // Tracker entries, indexed 1..DEPTH to match pipeline stage numbers.
  logic [DEPTH:1]   v_q,  v_d;
  logic [DEPTH:1]   ld_q, ld_d;
  logic [REG_W-1:0] rd_q [1:DEPTH];
  logic [REG_W-1:0] rd_d [1:DEPTH];

  logic [NUM_SRC-1:0] haz;
  logic               stall;

  // Per-operand select: the lowest-numbered matching entry is the newest
  // producer. If it is a load that has not reached stage LOAD_LAT+1 yet, the
  // operand is hazarded and older matches are deliberately ignored (stale).
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_op
      logic [SEL_W-1:0] sel_g;
      logic             haz_g;

      always_comb begin : p_sel
        logic [REG_W-1:0] src;
        logic             found;
        src   = bus.ex_src[gi*REG_W +: REG_W];
        sel_g = '0;
        haz_g = 1'b0;
        found = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
          if (!found && v_q[k] && (rd_q[k] == src) && (src != '0)) begin
            found = 1'b1;
            if (!ld_q[k] || (k > LOAD_LAT)) begin
              sel_g = SEL_W'(k);
            end else begin
              haz_g = 1'b1;
            end
          end
        end
      end

      assign bus.fwd_sel[gi*SEL_W +: SEL_W] = sel_g;
      assign haz[gi] = haz_g;
    end
  endgenerate

  assign stall     = bus.ex_valid & (|haz);
  assign bus.stall = stall;

  // Next state: hold freezes everything (including while stalled). Otherwise
  // shift and load entry 1; a stalled or flushed instruction enters as a
  // bubble, and rd=0 writers are never tracked.
  always_comb begin
    v_d  = v_q;
    ld_d = ld_q;
    rd_d = rd_q;
    if (!bus.hold) begin
      for (int k = DEPTH; k >= 2; k--) begin
        v_d[k]  = v_q[k-1];
        ld_d[k] = ld_q[k-1];
        rd_d[k] = rd_q[k-1];
      end
      v_d[1]  = bus.ex_valid & bus.ex_regwrite & ~stall & ~bus.flush &
                (bus.ex_rd != '0);
      rd_d[1] = bus.ex_rd;
      ld_d[1] = bus.ex_is_load;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q  <= '0;
      ld_q <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        rd_q[k] <= '0;
      end
    end else begin
      v_q  <= v_d;
      ld_q <= ld_d;
      rd_q <= rd_d;
    end
  end

`ifdef FWD_STATS_EN
  // Counts edges on which a stall actually costs a cycle (hold not active);
  // saturates instead of wrapping.
  logic [15:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && !bus.hold && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign bus.stall_count = stall_count_q;
`endif

endmodule
